multi_write_done_capture: RTL and testbench

MULTI_WRITE_DONE_CAPTURE -- requirements
Module: multi_write_done_capture

---
 rtl/eq_ctrl_pkg.sv | 21 ++
 rtl/write_done_capture_cell.sv | 62 ++++++
 rtl/multi_write_done_capture.sv | 76 +++++++
 tb/tb_multi_write_done_capture.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_ctrl_pkg.sv
// Shared equalizer-control definitions: default phase width, default commit
// phase and the commit-mode encodings used by the write-done capture logic.
package eq_ctrl_pkg;

   localparam int PHASE_W_DEF      = 6;
   localparam int COMMIT_PHASE_DEF = 63;

   // Commit mode: each band on its own, or every band in one shot.
   typedef enum logic {
      COMMIT_PER_BAND = 1'b0,
      COMMIT_ATOMIC   = 1'b1
   } commit_mode_e;

   localparam int ATOMIC_DEF = int'(COMMIT_PER_BAND);

   // True when the integer mode parameter selects all-bands-together commit.
   function automatic bit is_atomic(input int mode);
      return mode == int'(COMMIT_ATOMIC);
   endfunction

endpackage

// File: rtl/write_done_capture_cell.sv
// One band of write-done capture: rising-edge detect on the write-done level,
// a pending flag that holds a captured write until it is committed, and a
// sticky overrun flag for writes that arrive while one is already pending.
module write_done_capture_cell (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_write_done,
   input  logic i_commit,
   input  logic i_overrun_clr,
   output logic o_pending,
   output logic o_overrun
);

   logic r_prev;
   logic r_pending;
   logic r_overrun;
   logic w_rise;
   logic w_drop;
   logic w_pending_nxt;
   logic w_overrun_nxt;

   // Edges only count on enabled cycles; prev resets low, so a level that is
   // already high on the first enabled sample after reset reads as a capture.
   assign w_rise = i_en & i_write_done & ~r_prev;

   // A new write landing on an uncommitted one is dropped, not queued.
   assign w_drop = w_rise & r_pending & ~i_commit;

   // Next pending/overrun: a commit frees the slot, so a same-edge write
   // takes it over; an overrun set outranks a same-cycle clear.
   always_comb begin
      w_pending_nxt = r_pending;
      w_overrun_nxt = r_overrun;
      if (i_commit)
         w_pending_nxt = w_rise;
      else if (w_rise)
         w_pending_nxt = 1'b1;
      if (w_drop)
         w_overrun_nxt = 1'b1;
      else if (i_en & i_overrun_clr)
         w_overrun_nxt = 1'b0;
   end

   // Band state registers; prev only samples on enabled cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev    <= 1'b0;
         r_pending <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (i_en)
            r_prev <= i_write_done;
         r_pending <= w_pending_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   assign o_pending = r_pending;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/multi_write_done_capture.sv
// Multi-band write-done capture. Each band latches a coefficient write and
// holds it until the filter reaches the commit phase, then emits a one-cycle
// registered strobe. In atomic mode nothing commits until every band has a
// pending write, so a coefficient set is always swapped in as a whole.
module multi_write_done_capture
   import eq_ctrl_pkg::*;
#(
   parameter int N_BANDS      = 8,
   parameter int PHASE_W      = PHASE_W_DEF,
   parameter int COMMIT_PHASE = COMMIT_PHASE_DEF,
   parameter int ATOMIC       = ATOMIC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_enable,
   input  logic [N_BANDS-1:0] i_write_done,
   input  logic [PHASE_W-1:0] i_phase,
   input  logic               i_overrun_clr,
   output logic [N_BANDS-1:0] o_pending,
   output logic [N_BANDS-1:0] o_coeffs_en,
   output logic               o_busy,
   output logic [N_BANDS-1:0] o_overrun
);

   localparam logic [PHASE_W-1:0] L_COMMIT_PHASE = PHASE_W'(COMMIT_PHASE);
   localparam bit                 L_ATOMIC       = is_atomic(ATOMIC);

   logic [N_BANDS-1:0] w_pending;
   logic [N_BANDS-1:0] w_overrun;
   logic [N_BANDS-1:0] w_commit;
   logic [N_BANDS-1:0] r_coeffs_en;
   logic               w_commit_cycle;
   logic               w_all_pending;

   assign w_commit_cycle = clk_enable & (i_phase == L_COMMIT_PHASE);
   assign w_all_pending  = &w_pending;

   // Pick which bands commit this edge: per band, or all-or-nothing.
   always_comb begin
      w_commit = '0;
      if (L_ATOMIC)
         w_commit = {N_BANDS{w_commit_cycle & w_all_pending}};
      else
         w_commit = {N_BANDS{w_commit_cycle}} & w_pending;
   end

   genvar b;
   generate
      for (b = 0; b < N_BANDS; b++) begin : g_band
         write_done_capture_cell u_cell (
            .clk           (clk),
            .rst           (rst),
            .i_en          (clk_enable),
            .i_write_done  (i_write_done[b]),
            .i_commit      (w_commit[b]),
            .i_overrun_clr (i_overrun_clr),
            .o_pending     (w_pending[b]),
            .o_overrun     (w_overrun[b])
         );
      end
   endgenerate

   // Commit strobe is registered so no input reaches o_coeffs_en directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_coeffs_en <= '0;
      else
         r_coeffs_en <= w_commit;
   end

   assign o_pending   = w_pending;
   assign o_overrun   = w_overrun;
   assign o_coeffs_en = r_coeffs_en;
   assign o_busy      = |w_pending;

endmodule

// File: tb/tb_multi_write_done_capture.sv
// Bench for multi_write_done_capture: a per-band and an atomic instance share
// one stimulus stream; both are compared each cycle to a rule-level model.
module tb_multi_write_done_capture;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] wd;
   logic [5:0] ph;
   logic       clr;

   logic [7:0] p0, c0, v0, p1, c1, v1;
   logic       b0, b1;

   int    n_cmp = 0;
   int    n_err = 0;
   string scen  = "init";

   // model state: shared prev, per-instance pending/overrun/strobe
   logic [7:0] m_prev;
   logic [7:0] m_pend [2];
   logic [7:0] m_ovr  [2];
   logic [7:0] m_strb [2];

   multi_write_done_capture #(.ATOMIC(0)) u_dut0 (
      .clk(clk), .rst(rst), .clk_enable(en), .i_write_done(wd), .i_phase(ph),
      .i_overrun_clr(clr), .o_pending(p0), .o_coeffs_en(c0), .o_busy(b0),
      .o_overrun(v0));

   multi_write_done_capture #(.ATOMIC(1)) u_dut1 (
      .clk(clk), .rst(rst), .clk_enable(en), .i_write_done(wd), .i_phase(ph),
      .i_overrun_clr(clr), .o_pending(p1), .o_coeffs_en(c1), .o_busy(b1),
      .o_overrun(v1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_all();
      chk({scen, "_pend0"}, p0, m_pend[0]);
      chk({scen, "_strb0"}, c0, m_strb[0]);
      chk({scen, "_ovr0"},  v0, m_ovr[0]);
      chk({scen, "_busy0"}, {7'd0, b0}, {7'd0, |m_pend[0]});
      chk({scen, "_pend1"}, p1, m_pend[1]);
      chk({scen, "_strb1"}, c1, m_strb[1]);
      chk({scen, "_ovr1"},  v1, m_ovr[1]);
      chk({scen, "_busy1"}, {7'd0, b1}, {7'd0, |m_pend[1]});
   endtask

   // One clock: predict from the rules, take the edge, compare 1 after it.
   task automatic step();
      logic [7:0] n_pend [2];
      logic [7:0] n_ovr  [2];
      logic [7:0] n_strb [2];
      bit commit_cycle, rise, commit;
      int npend;
      commit_cycle = en && (ph == 6'd63);
      for (int k = 0; k < 2; k++) begin
         npend     = $countones(m_pend[k]);
         n_ovr[k]  = m_ovr[k];
         for (int b = 0; b < 8; b++) begin
            rise   = en && wd[b] && !m_prev[b];
            commit = commit_cycle && ((k == 0) ? m_pend[k][b] : (npend == 8));
            n_strb[k][b] = commit;
            n_pend[k][b] = commit ? rise : (m_pend[k][b] | rise);
            if (rise && m_pend[k][b] && !commit) n_ovr[k][b] = 1'b1;
            else if (en && clr)                  n_ovr[k][b] = 1'b0;
         end
      end
      @(posedge clk);
      if (en) m_prev = wd;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = n_pend[k];
         m_ovr[k]  = n_ovr[k];
         m_strb[k] = n_strb[k];
      end
      #1;
      check_all();
   endtask

   task automatic tick();
      step();
      ph = ph + 6'd1;
   endtask

   task automatic run_until(input logic [5:0] target);
      while (ph != target) tick();
   endtask

   // Asynchronous reset in the middle of a cycle, release on a falling edge.
   task automatic do_reset();
      #2;
      rst    = 1'b0;
      m_prev = '0;
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = '0; m_ovr[k] = '0; m_strb[k] = '0;
      end
      #1;
      check_all();
      wd  = '0;
      clr = 1'b0;
      en  = 1'b1;
      ph  = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; wd = '0; ph = '0; clr = 1'b0;

      scen = "reset";
      do_reset();

      // single band capture and commit
      scen = "A";
      run_until(6'd10); wd[2] = 1'b1; tick();
      run_until(6'd63);
      chk("A_pend_hold", p0, 8'h04);
      tick();
      chk("A_strobe", c0, 8'h04);
      chk("A_pend_clr", p0, 8'h00);
      tick();
      chk("A_strobe_one_cycle", c0, 8'h00);

      // overrun, single strobe, clear, set beats clear
      scen = "B";
      do_reset();
      run_until(6'd10); wd[5] = 1'b1; tick();
      run_until(6'd15); wd[5] = 1'b0; tick();
      run_until(6'd20); wd[5] = 1'b1; tick();
      chk("B_ovr_set", v0, 8'h20);
      run_until(6'd63); tick();
      chk("B_strobe", c0, 8'h20);
      tick();
      chk("B_single_strobe", c0, 8'h00);
      clr = 1'b1; tick(); clr = 1'b0;
      chk("B_ovr_clr", v0, 8'h00);
      wd[5] = 1'b0; tick();
      wd[5] = 1'b1; tick();
      wd[5] = 1'b0; tick();
      wd[5] = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
      chk("B_set_beats_clr", v0, 8'h20);

      // edge coincident with commit
      scen = "C";
      do_reset();
      run_until(6'd5);  wd[0] = 1'b1; tick();
      run_until(6'd30); wd[0] = 1'b0; tick();
      run_until(6'd63); wd[0] = 1'b1; tick();
      chk("C_strobe", c0, 8'h01);
      chk("C_pend_kept", p0 & 8'h01, 8'h01);
      chk("C_no_ovr", v0, 8'h00);
      run_until(6'd63); tick();
      chk("C_second_strobe", c0, 8'h01);

      // atomic: nothing until all bands pending
      scen = "D";
      do_reset();
      run_until(6'd5); wd = 8'h7F; tick();
      run_until(6'd63); tick();
      chk("D_no_strobe", c1, 8'h00);
      chk("D_pend", p1, 8'h7F);
      run_until(6'd5); wd = 8'hFF; tick();
      run_until(6'd63); tick();
      chk("D_all_strobe", c1, 8'hFF);
      chk("D_pend_clr", p1, 8'h00);

      // clock enable low across the commit phase
      scen = "E";
      do_reset();
      run_until(6'd5); wd[3] = 1'b1; tick();
      run_until(6'd63);
      en = 1'b0;
      repeat (3) begin ph = 6'd63; step(); end
      chk("E_no_strobe", c0, 8'h00);
      chk("E_pend_held", p0, 8'h08);
      en = 1'b1; ph = '0;
      run_until(6'd63); tick();
      chk("E_strobe", c0, 8'h08);

      // reset with writes pending
      scen = "F";
      do_reset();
      run_until(6'd5); wd = 8'hAA; tick(); tick(); tick();
      chk("F_pend_before", p0, 8'hAA);
      do_reset();
      chk("F_pend_zero", p0 | p1, 8'h00);
      chk("F_ovr_zero", v0 | v1, 8'h00);
      run_until(6'd63); tick();
      chk("F_no_strobe", c0 | c1, 8'h00);

      // random traffic against the model
      scen = "R";
      do_reset();
      for (int i = 0; i < 600; i++) begin
         wd  = wd ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         en  = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 19) == 0);
         ph  = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
